// File: rtl/polar_conv_ctrl.sv
// polar_conv_ctrl: sequenced rectangular-to-polar converter for unsigned
// first-quadrant (x, y). A single shift-subtract unit is time-shared between
// a restoring square root (r) and a restoring ratio divide (atan LUT index).
module polar_conv_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_r,
  output logic [7:0]        out_theta,
  output logic              busy
);

  // Sum is padded to an even width so the root consumes whole bit pairs.
  localparam int SUM_W = 2 * DATA_W + 2;
  // Partial remainder: root remainder stays below 2^(DATA_W+2) before the
  // 2-bit shift; the divide remainder stays below 2^(DATA_W+1).
  localparam int REM_W = DATA_W + 5;

  typedef enum logic [2:0] {
    S_IDLE, S_SQ, S_ROOT, S_DIV, S_FIN, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic [SUM_W-1:0]  r_sum;
  logic [REM_W-1:0]  r_rem;
  logic [DATA_W:0]   r_root;
  logic [4:0]        r_quo;
  logic [3:0]        r_cnt;
  logic [DATA_W:0]   r_out_r;
  logic [7:0]        r_out_theta;

  logic [DATA_W-1:0] w_mn;
  logic [DATA_W-1:0] w_mx;
  logic              w_swp;
  logic [SUM_W-1:0]  w_sq;
  logic [REM_W-1:0]  w_sub_a;
  logic [REM_W-1:0]  w_sub_b;
  logic [REM_W-1:0]  w_diff;
  logic              w_ge;
  logic [4:0]        w_k;
  logic [7:0]        w_atan;
  logic [7:0]        w_theta;

  // atan(k/16) in whole degrees, k = 0..16.
  function automatic logic [7:0] atan_lut(input logic [4:0] k);
    case (k)
      5'd0:    atan_lut = 8'd0;
      5'd1:    atan_lut = 8'd4;
      5'd2:    atan_lut = 8'd7;
      5'd3:    atan_lut = 8'd11;
      5'd4:    atan_lut = 8'd14;
      5'd5:    atan_lut = 8'd17;
      5'd6:    atan_lut = 8'd21;
      5'd7:    atan_lut = 8'd24;
      5'd8:    atan_lut = 8'd27;
      5'd9:    atan_lut = 8'd29;
      5'd10:   atan_lut = 8'd32;
      5'd11:   atan_lut = 8'd35;
      5'd12:   atan_lut = 8'd37;
      5'd13:   atan_lut = 8'd39;
      5'd14:   atan_lut = 8'd41;
      5'd15:   atan_lut = 8'd43;
      default: atan_lut = 8'd45;
    endcase
  endfunction

  assign w_swp = (r_y > r_x);
  assign w_mn  = w_swp ? r_x : r_y;
  assign w_mx  = w_swp ? r_y : r_x;
  assign w_sq  = SUM_W'(r_x) * SUM_W'(r_x) + SUM_W'(r_y) * SUM_W'(r_y);

  // Shared shift-subtract unit: operand selection depends on the active job.
  always_comb begin
    w_sub_a = '0;
    w_sub_b = '0;
    if (r_state == S_ROOT) begin
      w_sub_a = {r_rem[REM_W-3:0], r_sum[SUM_W-1 -: 2]};
      w_sub_b = {2'b00, r_root, 2'b01};
    end else if (r_state == S_DIV) begin
      // First divide step produces the integer bit (mn == mx gives k = 16).
      w_sub_a = (r_cnt == 4'd5) ? r_rem : {r_rem[REM_W-2:0], 1'b0};
      w_sub_b = {{(REM_W-DATA_W){1'b0}}, w_mx};
    end
  end

  assign w_ge   = (w_sub_a >= w_sub_b);
  assign w_diff = w_sub_a - w_sub_b;

  // A zero max means x = y = 0; the divide result is meaningless there.
  assign w_k     = (w_mx == '0) ? 5'd0 : r_quo;
  assign w_atan  = atan_lut(w_k);
  assign w_theta = w_swp ? (8'd90 - w_atan) : w_atan;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake outputs; every transition is gated by ena.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (ena && in_valid) w_state_next = S_SQ;
      end
      S_SQ:   if (ena) w_state_next = S_ROOT;
      S_ROOT: if (ena && r_cnt == 4'd1) w_state_next = S_DIV;
      S_DIV:  if (ena && r_cnt == 4'd1) w_state_next = S_FIN;
      S_FIN:  if (ena) w_state_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (ena && out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, square, root/divide iterations, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_sum       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_out_r     <= '0;
      r_out_theta <= '0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x <= in_x;
            r_y <= in_y;
          end
        end
        S_SQ: begin
          r_sum  <= w_sq;
          r_rem  <= '0;
          r_root <= '0;
          r_cnt  <= 4'(DATA_W + 1);
        end
        S_ROOT: begin
          r_sum  <= {r_sum[SUM_W-3:0], 2'b00};
          r_rem  <= w_ge ? w_diff : w_sub_a;
          r_root <= {r_root[DATA_W-1:0], w_ge};
          r_cnt  <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            // Hand the unit over to the divide, seeded with the minimum.
            r_rem <= {{(REM_W-DATA_W){1'b0}}, w_mn};
            r_quo <= '0;
            r_cnt <= 4'd5;
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_diff : w_sub_a;
          r_quo <= {r_quo[3:0], w_ge};
          r_cnt <= r_cnt - 4'd1;
        end
        S_FIN: begin
          r_out_r     <= r_root;
          r_out_theta <= w_theta;
        end
        default: ;
      endcase
    end
  end

  assign out_r     = r_out_r;
  assign out_theta = r_out_theta;

endmodule

// File: tb/tb_polar_conv_ctrl.sv
// Directed plus randomized bench for polar_conv_ctrl against an arithmetic
// reference model (integer square root by search, atan LUT by ratio).
module tb_polar_conv_ctrl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_r;
  logic [7:0]        out_theta;
  logic              busy;

  int n_vec  = 0;
  int n_miss = 0;

  polar_conv_ctrl #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_theta (out_theta),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_r(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int ref_theta(input int x, input int y);
    int lut [0:16];
    int mn;
    int mx;
    int k;
    lut = '{0, 4, 7, 11, 14, 17, 21, 24, 27, 29, 32, 35, 37, 39, 41, 43, 45};
    mn = (x < y) ? x : y;
    mx = (x < y) ? y : x;
    k  = (mx == 0) ? 0 : (mn * 16) / mx;
    return (y > x) ? 90 - lut[k] : lut[k];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a request and return just after the accept edge.
  task automatic wait_accept(input int x, input int y);
    int cyc;
    in_x     = DATA_W'(x);
    in_y     = DATA_W'(y);
    in_valid = 1'b1;
    cyc      = 0;
    while (!in_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("accept_timeout", 32'(cyc), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 0);
    chk("consume_ready", 32'(in_ready), 1);
  endtask

  task automatic txn(input int x, input int y);
    int lat;
    wait_accept(x, y);
    wait_result(lat);
    chk("latency", 32'(lat), DATA_W + 8);
    chk("r", 32'(out_r), 32'(ref_r(x, y)));
    chk("theta", 32'(out_theta), 32'(ref_theta(x, y)));
    $display("txn x=%0d y=%0d r=%0d theta=%0d lat=%0d", x, y, out_r, out_theta, lat);
    consume();
  endtask

  initial begin
    int lat;
    int held_ok;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_r", 32'(out_r), 0);
    chk("rst_out_theta", 32'(out_theta), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner points.
    txn(3, 4);
    chk("r_3_4", 32'(out_r), 5);
    chk("theta_3_4", 32'(out_theta), 53);
    txn(255, 255);
    chk("r_max", 32'(out_r), 360);
    chk("theta_max", 32'(out_theta), 45);
    txn(0, 0);
    txn(100, 0);
    txn(0, 7);
    chk("theta_x0", 32'(out_theta), 90);

    // Backpressure with a second request held on the input.
    wait_accept(3, 4);
    in_x = 8'd5; in_y = 8'd12; in_valid = 1'b1;
    wait_result(lat);
    chk("bp_latency", 32'(lat), 16);
    held_ok = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_r != 9'd5 || out_theta != 8'd53) held_ok = 0;
    end
    chk("bp_hold", 32'(held_ok), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_drop_valid", 32'(out_valid), 0);
    chk("bp_idle_ready", 32'(in_ready), 1);
    chk("bp_keep_r", 32'(out_r), 5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", 32'(busy), 1);
    wait_result(lat);
    chk("bp2_latency", 32'(lat), 16);
    chk("bp2_r", 32'(out_r), 32'(ref_r(5, 12)));
    chk("bp2_theta", 32'(out_theta), 69);
    $display("txn x=5 y=12 r=%0d theta=%0d lat=%0d", out_r, out_theta, lat);
    consume();

    // Asynchronous reset in the fourth root cycle.
    wait_accept(255, 255);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_r", 32'(out_r), 0);
    chk("arst_out_theta", 32'(out_theta), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(3, 4);

    // Enable dropped for five cycles while the divide is running.
    wait_accept(3, 4);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 11) ena = 1'b0;
      if (lat == 16) begin
        chk("ena_busy", 32'(busy), 1);
        ena = 1'b1;
      end
    end
    chk("ena_latency", 32'(lat), 21);
    chk("ena_r", 32'(out_r), 5);
    chk("ena_theta", 32'(out_theta), 53);
    $display("txn x=3 y=4 ena-gap r=%0d theta=%0d lat=%0d", out_r, out_theta, lat);
    consume();

    // Randomized operands against the reference model.
    for (int i = 0; i < 24; i++) begin
      txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
